// File: rtl/fp16_stream_unpack.sv
// Splits 32-bit DMA words (two little-endian fp16 halves) into one converter-ready word per half.
// Optional m_zero exponent flag is built only when UNPACK_ZERO_FLAG_EN is defined.
module fp16_stream_unpack #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_half_only,
  output logic             s_ready,
  output logic [31:0]      m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_zero,
  input  logic             m_ready,
  output logic [CNT_W-1:0] elem_count,
  output logic             busy
);

  typedef enum logic [1:0] {StEmpty, StLo, StHi} state_e;

  state_e             state_q, state_d;
  logic [15:0]        hold_q, hold_d;
  logic               held_last_q, held_last_d;
  logic               held_half_only_q, held_half_only_d;
  logic [31:0]        m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        next_half;
  logic               load_new, load_hi, go_empty;
  logic               s_accept, m_hs;

  // Half-only last word in LO frees the slot as soon as its single beat is taken.
  always_comb begin
    s_ready = (state_q == StEmpty) ||
              ((state_q == StHi) && m_ready) ||
              ((state_q == StLo) && held_half_only_q && held_last_q && m_ready);
  end

  assign s_accept = s_valid && s_ready;
  assign m_hs     = m_valid_q && m_ready;

  always_comb begin
    load_new = 1'b0;
    load_hi  = 1'b0;
    go_empty = 1'b0;
    unique case (state_q)
      StEmpty: load_new = s_accept;
      StLo: begin
        if (m_hs) begin
          if (held_last_q && held_half_only_q) begin
            load_new = s_accept;
            go_empty = !s_accept;
          end else begin
            load_hi = 1'b1;
          end
        end
      end
      StHi: begin
        if (m_hs) begin
          load_new = s_accept;
          go_empty = !s_accept;
        end
      end
      default: go_empty = 1'b1;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    hold_d           = hold_q;
    held_last_d      = held_last_q;
    held_half_only_d = held_half_only_q;
    m_data_d         = m_data_q;
    m_valid_d        = m_valid_q;
    m_last_d         = m_last_q;
    next_half        = 16'h0000;
    if (load_new) begin
      state_d          = StLo;
      hold_d           = s_data[31:16];
      held_last_d      = s_last;
      held_half_only_d = s_last && s_half_only;
      next_half        = s_data[15:0];
      m_data_d         = {s_data[7:0], s_data[15:8], 16'h0000};
      m_valid_d        = 1'b1;
      m_last_d         = s_last && s_half_only;
    end else if (load_hi) begin
      state_d   = StHi;
      next_half = hold_q;
      m_data_d  = {hold_q[7:0], hold_q[15:8], 16'h0000};
      m_last_d  = held_last_q;
    end else if (go_empty) begin
      state_d   = StEmpty;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  // Count restarts after the final half so the next packet begins at zero.
  always_comb begin
    count_d = count_q;
    if (m_hs) begin
      if (m_last_q) begin
        count_d = '0;
      end else if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StEmpty;
      hold_q           <= 16'h0000;
      held_last_q      <= 1'b0;
      held_half_only_q <= 1'b0;
      m_data_q         <= 32'h0000_0000;
      m_valid_q        <= 1'b0;
      m_last_q         <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      hold_q           <= hold_d;
      held_last_q      <= held_last_d;
      held_half_only_q <= held_half_only_d;
      m_data_q         <= m_data_d;
      m_valid_q        <= m_valid_d;
      m_last_q         <= m_last_d;
      count_q          <= count_d;
    end
  end

`ifdef UNPACK_ZERO_FLAG_EN
  // Zero/denormal halves must become fp32 zero; the converter's bias would make them nonzero.
  logic m_zero_q, m_zero_d;

  always_comb begin
    m_zero_d = m_zero_q;
    if (load_new || load_hi) begin
      m_zero_d = (next_half[14:10] == 5'd0);
    end else if (go_empty) begin
      m_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_zero_q <= 1'b0;
    end else begin
      m_zero_q <= m_zero_d;
    end
  end

  assign m_zero = m_zero_q;
`else
  assign m_zero = 1'b0;
`endif

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign elem_count = count_q;
  assign busy       = (state_q != StEmpty);

endmodule

// File: tb/tb_fp16_stream_unpack.sv
// Directed and randomized self-checking bench for fp16_stream_unpack.
module tb_fp16_stream_unpack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_half_only = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_zero;
  logic        m_ready = 1'b0;
  logic [15:0] elem_count;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  fp16_stream_unpack #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_half_only(s_half_only), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_zero(m_zero), .m_ready(m_ready), .elem_count(elem_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    vectors++; if (m_data !== 32'h0) begin miscompares++; $display("FAIL reset_m_data got=%h want=00000000", m_data); end
    vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL reset_m_last got=%b want=0", m_last); end
    vectors++; if (m_zero !== 1'b0) begin miscompares++; $display("FAIL reset_m_zero got=%b want=0", m_zero); end
    vectors++; if (elem_count !== 16'd0) begin miscompares++; $display("FAIL reset_count got=%0d want=0", elem_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_single();
    s_data = 32'h3C00_4000; s_last = 1'b1; s_half_only = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'h0040_0000 || m_last !== 1'b0) begin
      miscompares++; $display("FAIL single_beat0 got=%b/%h/%b want=1/00400000/0", m_valid, m_data, m_last); end
    vectors++; if (elem_count !== 16'd0) begin miscompares++; $display("FAIL single_count0 got=%0d want=0", elem_count); end
    tick();
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'h003C_0000 || m_last !== 1'b1) begin
      miscompares++; $display("FAIL single_beat1 got=%b/%h/%b want=1/003c0000/1", m_valid, m_data, m_last); end
    vectors++; if (elem_count !== 16'd1) begin miscompares++; $display("FAIL single_count1 got=%0d want=1", elem_count); end
    tick();
    vectors++; if (m_valid !== 1'b0 || elem_count !== 16'd0) begin
      miscompares++; $display("FAIL single_after got=%b/%0d want=0/0", m_valid, elem_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic [31:0] exp [8];
    int idx;
    int beat;
    bit acc;
    words[0] = 32'hAABB_CCDD; words[1] = 32'h1234_5678;
    words[2] = 32'h0001_8000; words[3] = 32'hFEDC_BA98;
    exp[0] = 32'hDDCC_0000; exp[1] = 32'hBBAA_0000; exp[2] = 32'h7856_0000; exp[3] = 32'h3412_0000;
    exp[4] = 32'h0080_0000; exp[5] = 32'h0100_0000; exp[6] = 32'h98BA_0000; exp[7] = 32'hDCFE_0000;
    idx = 0; beat = 0; m_ready = 1'b1; s_half_only = 1'b0;
    for (int c = 0; c < 12; c++) begin
      s_valid = (idx < 4);
      s_data  = (idx < 4) ? words[idx] : 32'h0;
      s_last  = (idx == 3);
      #1;
      acc = s_valid && s_ready;
      if (beat > 0 && beat < 8 && !m_valid) begin
        vectors++; miscompares++; $display("FAIL b2b_bubble beat=%0d got m_valid=0 want 1", beat);
      end
      if (m_valid && m_ready && beat < 8) begin
        vectors++; if (m_data !== exp[beat] || m_last !== (beat == 7)) begin
          miscompares++; $display("FAIL b2b_beat%0d got=%h/%b want=%h/%b", beat, m_data, m_last, exp[beat], beat == 7); end
        vectors++; if (s_ready !== beat[0]) begin
          miscompares++; $display("FAIL b2b_s_ready%0d got=%b want=%b", beat, s_ready, beat[0]); end
        beat++;
      end
      tick();
      if (acc) idx++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    vectors++; if (beat != 8 || m_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_total got=%0d/%b want=8/0", beat, m_valid); end
  endtask

  task automatic test_backpressure();
    s_data = 32'h5566_7788; s_last = 1'b1; s_half_only = 1'b0; s_valid = 1'b1; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (m_valid !== 1'b1 || m_data !== 32'h8877_0000 || m_last !== 1'b0 || s_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b want=1/88770000/0/0", i, m_valid, m_data, m_last, s_ready); end
      tick();
    end
    m_ready = 1'b1;
    tick();
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'h6655_0000 || m_last !== 1'b1 || elem_count !== 16'd1) begin
      miscompares++; $display("FAIL bp_resume got=%b/%h/%b/%0d want=1/66550000/1/1", m_valid, m_data, m_last, elem_count); end
    tick();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_end got=%b want=0", m_valid); end
  endtask

  task automatic test_half_only();
    logic exp_zero;
`ifdef UNPACK_ZERO_FLAG_EN
    exp_zero = 1'b1;
`else
    exp_zero = 1'b0;
`endif
    s_data = 32'hFFFF_8000; s_last = 1'b1; s_half_only = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'h0080_0000 || m_last !== 1'b1 || m_zero !== exp_zero) begin
      miscompares++; $display("FAIL ho_beat got=%b/%h/%b/%b want=1/00800000/1/%b", m_valid, m_data, m_last, m_zero, exp_zero); end
    s_data = 32'h0000_3C00; s_last = 1'b1; s_half_only = 1'b0;
    #1;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL ho_s_ready got=%b want=1", s_ready); end
    tick();
    s_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'h003C_0000 || m_last !== 1'b0 || elem_count !== 16'd0) begin
      miscompares++; $display("FAIL ho_next0 got=%b/%h/%b/%0d want=1/003c0000/0/0", m_valid, m_data, m_last, elem_count); end
    tick();
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'h0 || m_last !== 1'b1) begin
      miscompares++; $display("FAIL ho_next1 got=%b/%h/%b want=1/00000000/1", m_valid, m_data, m_last); end
    tick();
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL ho_end got=%b want=0", m_valid); end
  endtask

  task automatic test_reset_mid();
    s_data = 32'hABCD_1234; s_last = 1'b0; s_half_only = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    vectors++; if (m_data !== 32'hCDAB_0000 || busy !== 1'b1) begin
      miscompares++; $display("FAIL rm_hi got=%h/%b want=cdab0000/1", m_data, busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0 || busy !== 1'b0 || elem_count !== 16'd0) begin
      miscompares++; $display("FAIL rm_cleared got=%b/%h/%b/%b/%0d want=0/00000000/0/0/0", m_valid, m_data, m_last, busy, elem_count); end
    s_data = 32'h1122_3344; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'h4433_0000 || m_last !== 1'b0) begin
      miscompares++; $display("FAIL rm_new0 got=%b/%h/%b want=1/44330000/0", m_valid, m_data, m_last); end
    tick();
    vectors++; if (m_valid !== 1'b1 || m_data !== 32'h2211_0000 || m_last !== 1'b1) begin
      miscompares++; $display("FAIL rm_new1 got=%b/%h/%b want=1/22110000/1", m_valid, m_data, m_last); end
    tick();
  endtask

  logic [31:0] exp_q [$];
  bit          last_q [$];

  task automatic test_random();
    int sent, pkt_left, pkt_beats, cycles;
    bit acc, prev_stall, prev_last, ho;
    logic [31:0] prev_data, e;
    bit el;
    sent = 0; pkt_left = 0; pkt_beats = 0; cycles = 0; prev_stall = 0;
    prev_data = '0; prev_last = 0;
    s_valid = 1'b0;
    while ((sent < 1000 || exp_q.size() > 0) && cycles < 20000) begin
      if (prev_stall) begin
        vectors++; if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          miscompares++; $display("FAIL rnd_stable cyc=%0d got=%b/%h/%b want=1/%h/%b", cycles, m_valid, m_data, m_last, prev_data, prev_last); end
      end
      if (!s_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        if (pkt_left == 0) pkt_left = $urandom_range(1, 4);
        s_valid = 1'b1;
        s_data = $urandom;
        s_last = (pkt_left == 1);
        s_half_only = $urandom_range(0, 1) == 1;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = s_valid && s_ready;
      if (acc) begin
        ho = s_last && s_half_only;
        exp_q.push_back({s_data[7:0], s_data[15:8], 16'h0000});
        last_q.push_back(ho);
        if (!ho) begin
          exp_q.push_back({s_data[23:16], s_data[31:24], 16'h0000});
          last_q.push_back(s_last);
        end
        sent++; pkt_left--;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++; $display("FAIL rnd_extra got=%h want=no beat", m_data);
        end else begin
          e = exp_q.pop_front(); el = last_q.pop_front();
          vectors++; if (m_data !== e || m_last !== el || elem_count !== pkt_beats[15:0]) begin
            miscompares++; $display("FAIL rnd_beat got=%h/%b/%0d want=%h/%b/%0d", m_data, m_last, elem_count, e, el, pkt_beats); end
          pkt_beats = el ? 0 : pkt_beats + 1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data; prev_last = m_last;
      tick();
      cycles++;
      if (acc) s_valid = 1'b0;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    vectors++; if (sent != 1000 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL rnd_timeout got=%0d words/%0d pending want=1000/0", sent, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_half_only();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp16_stream_unpack.md
# fp16_stream_unpack

Upstream feeder for the fp16→fp32 converter. It accepts a valid/ready stream of 32-bit DMA words, each packing two fp16 values in little-endian order. It emits one 32-bit word per fp16 value, laid out exactly as the converter consumes it: half low byte in [31:24], half high byte in [23:16], [15:0] zero. The converter then byte-swaps and widens combinationally.

## Interface
- CNT_W, 16, width of per-packet element counter

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- s_data  in  32  input word; half0 = s_data[15:0], half1 = s_data[31:16] (each: [7:0] low byte, [15:8] high byte)
- s_valid  in  1  input word valid
- s_last  in  1  word is last of packet
- s_half_only  in  1  qualified by s_last: only half0 of this word is valid
- s_ready  out  1  block accepts s_data this cycle
- m_data  out  32  {half[7:0], half[15:8], 16'h0000}
- m_valid  out  1  m_data valid
- m_last  out  1  final half of packet
- m_zero  out  1  half exponent field (half[14:10]) is 0; see Configuration
- m_ready  in  1  downstream accepts m_data
- elem_count  out  CNT_W  halves handed off in current packet
- busy  out  1  holding a word (state != EMPTY)

## Operation
- Input handshake: s_valid && s_ready. Output handshake: m_valid && m_ready.
- States:
  - EMPTY: nothing held.
  - LO: presenting half0 of held word.
  - HI: presenting half1.
- Holding register: 16 bits for the pending half1, plus held last and half_only flags. m_* are registered.
- s_ready = (state==EMPTY) || (state==HI && m_ready) || (state==LO && held_half_only && held_last && m_ready). This is combinational from m_ready and state only; it never depends on s_valid.
- EMPTY + input handshake → LO: m_data loaded from half0; half1 stored.
- LO + output handshake:
  - If held_last && held_half_only: half0 is final. m_last was 1 during LO. Go to LO if a new word is accepted the same cycle, else EMPTY.
  - Otherwise go to HI and load m_data from stored half1.
- HI + output handshake: go to LO if a new word is accepted the same cycle (back-to-back, 1 half/cycle sustained), else EMPTY.
- m_last = 1 only on the final half: half1 of an s_last word, or half0 when s_half_only.
- s_half_only without s_last is ignored; both halves are emitted.
- m_valid must not drop while m_ready=0. m_data, m_last and m_zero stay stable under backpressure.
- elem_count:
  - Increments on each output handshake and saturates at all-ones.
  - On the handshake carrying m_last it reads 0 the next cycle. The final count is visible only before that beat.

## Timing
- Reset values: state EMPTY, m_valid 0, m_data 0, m_last 0, m_zero 0, elem_count 0, busy 0. s_ready is 1 the first cycle after reset deasserts.
- Latency: a word accepted at edge N presents half0 with m_valid=1 after edge N. Half1 appears the cycle after half0 is handed off.
- Throughput: one half per cycle with m_ready held at 1, i.e. one input word every 2 cycles. A half-only last word takes 1 cycle.
- Reset mid-operation: held word and flags are discarded, all outputs return to reset values at the next edge, and no partial half is emitted afterwards.
- Simultaneous output handshake and input accept: the output register loads the new half0 and m_valid stays 1, with no bubble.

## Configuration
- UNPACK_ZERO_FLAG_EN:
  - Defined: m_zero is registered alongside m_data and equals 1 when the presented half has exponent bits 0 (zero/denormal). Downstream uses it to force fp32 zero, since the converter's +112 bias otherwise maps these to nonzero values.
  - Undefined: m_zero is tied 0 and no comparison logic exists.

## Test plan
- Single word s_data=32'h3C00_4000, s_last=1, m_ready=1 → m_data 32'h0040_0000 (m_last=0), then 32'h003C_0000 (m_last=1), then m_valid=0. elem_count reads 1 on the second beat, then 0.
- Four words back-to-back, m_ready=1 → 8 contiguous m_valid cycles. s_ready is high on every HI cycle; m_last only on the 8th beat.
- Backpressure: hold m_ready=0 for 5 cycles while in LO → m_data, m_last and m_valid are stable and s_ready=0. Release → sequence resumes with nothing lost or duplicated.
- s_data=32'hFFFF_8000, s_last=1, s_half_only=1 → one beat with m_data=32'h0080_0000 and m_last=1. With UNPACK_ZERO_FLAG_EN defined, m_zero=1.
- Assert reset while in HI with m_ready=0 → next cycle all outputs are 0 and state is EMPTY. A new word then yields its own half0 first.
- Random s_valid/m_ready toggling over 1000 words, scoreboarding halves in order → no mismatch; elem_count equals the number of halves per packet.
